sram_arb_ctrl: RTL and testbench
================================

Name: sram_arb_ctrl

Overview:
Cycle-sequenced controller and two-port arbiter for the 2048x8 asynchronous board SRAM. It shares the SRAM between the game-logic requester (port 0) and the wireless/serial link requester (port 1). It converts single-cycle-latched read/write requests into properly timed chip-select, output-enable and read-not-write strobes. A write commits on the rising edge of the read-not-write strobe.

Parameters:
ADDR_W, 11, SRAM address width (2048 bytes)
DATA_W, 8, SRAM data width
RD_WAIT, 2, cycles output-enable is held low before read data is sampled (min 1)
WR_PULSE, 2, cycles read-not-write is held low during a write (min 1)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 request; hold high with fields stable until ack0
rnw0  in  1  port 0: 1 = read, 0 = write
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  one-cycle completion pulse for port 0
req1, rnw1, addr1, wdata1, ack1  same as port 0, for port 1
rdata  out  DATA_W  read data; valid in the cycle ack0 or ack1 pulses for a read
sram_addr  out  ADDR_W  SRAM address
sram_data  inout  DATA_W  SRAM data bus; driven only in write states, else high-Z
sram_noe  out  1  SRAM output enable, active low
sram_rnw  out  1  SRAM read-not-write; rising edge commits a write
sram_ncs  out  1  SRAM chip select, active low
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, immediate) forces:
  - state IDLE; sram_ncs = 1, sram_noe = 1, sram_rnw = 1; sram_data high-Z
  - ack0 = ack1 = 0; rdata = 0; sram_addr = 0; busy = 0
  - arbiter pointer favours port 0.
- All SRAM control outputs come straight from registers, with no combinational glitches.
- sram_noe and sram_rnw are never both low. sram_data is never driven while sram_noe is low.
- Arbitration happens in IDLE only, round-robin:
  - One requester high: it wins.
  - Both high: the pointer side wins, then the pointer flips to the other port.
  - Grant cycle T latches rnw, addr and wdata of the winner into internal registers.
- States and transitions:
  - IDLE -> RD_WAIT or WR_SETUP at T+1.
  - RD_WAIT: ncs = 0, noe = 0, address driven. Lasts RD_WAIT cycles. sram_data is sampled into rdata on the last cycle's clock edge. -> DONE.
  - WR_SETUP: 1 cycle; ncs = 0, rnw = 1, address and data driven. -> WR_PULSE.
  - WR_PULSE: rnw = 0 for WR_PULSE cycles. -> WR_HOLD.
  - WR_HOLD: 1 cycle; rnw = 1, which is the commit edge. ncs = 0 and data stay driven. -> DONE.
  - DONE: 1 cycle; ncs = noe = rnw = 1, bus released; ack of the granted port = 1. -> IDLE.
- Latency from grant cycle T to ack: read T+RD_WAIT+1; write T+WR_PULSE+3.
- Minimum request spacing: one IDLE cycle between transactions.
  - A requester whose req stays high after ack is treated as a new request.
- A latched transaction always completes, even if req drops early.
- A request arriving while busy waits; there is no pre-emption.
- Reset mid-transaction: the transaction is aborted with no ack.
  - The byte at the in-flight write address is undefined.
  - All other SRAM contents are untouched.
- Address wrap: none; addresses are passed through unmodified.
- Counter width is clog2 of max(RD_WAIT, WR_PULSE), plus 1.

Decomposition:
- Shared include file sram_ctrl_defs holds:
  - state encodings: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  - default ADDR_W and DATA_W
- One sub-module, rr_arb2: two-request round-robin arbiter with enable (IDLE) input, grant outputs and pointer register.

Test Plan:
- Reset released, no requests -> ncs/noe/rnw = 1, bus high-Z, busy = 0, acks 0 for 20 cycles.
- Port 0 writes 0xA5 to 0x123, then reads 0x123 -> write ack at T+5, read ack at T+3 with rdata = 0xA5. rnw rises exactly once, with ncs low and data 0xA5.
- req0 and req1 asserted together, reading 0x000 and 0x7FF, both held -> port 0 served first, then port 1. Next simultaneous pair serves port 1 first. Acks never overlap.
- Port 1 writes 0x3C to 0x7FF, then port 0 reads 0x7FF -> rdata = 0x3C. noe and rnw are never low together, checked every cycle.
- Reset asserted during WR_PULSE -> outputs idle immediately, no ack. A following port 0 read of a different pre-written address returns its original value.
- RD_WAIT = 4, WR_PULSE = 1 build -> read ack at T+5, write ack at T+4. rnw is low for exactly 1 cycle.

Source files
------------

// File: rtl/sram_arb_ctrl_pkg.sv
// Shared types and defaults for the board SRAM arbiter/controller.
// Holds the FSM state encoding and default bus widths.
package sram_arb_ctrl_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/sram_arb_ctrl_rr_arb2.sv
// Two-request round-robin arbiter, active only while enabled.
// The pointer moves only when both ports contend.
module rr_arb2
  import sram_arb_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ptr_d = ptr_q;
    if (en) begin
      if (req0 && req1) begin
        gnt0  = ~ptr_q;
        gnt1  = ptr_q;
        ptr_d = ~ptr_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-port arbiter and strobe sequencer for the 2048x8 async SRAM.
// Every SRAM control pin is driven straight from a flop.
module sram_arb_ctrl
  import sram_arb_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_WAIT  = 2,
  parameter int WR_PULSE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              rnw0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              rnw1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_noe,
  output logic              sram_rnw,
  output logic              sram_ncs,
  output logic              busy
);

  localparam int CNT_W = cnt_width(RD_WAIT, WR_PULSE);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ncs_q, ncs_d;
  logic              noe_q, noe_d;
  logic              wr_q, wr_d;
  logic              drv_q, drv_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              gnt0, gnt1;
  logic              sel_rd;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_IDLE),
    .req0  (req0),
    .req1  (req1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ncs_d   = ncs_q;
    noe_d   = noe_q;
    wr_d    = wr_q;
    drv_d   = drv_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    sel_rd  = gnt1 ? rnw1 : rnw0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          port_d  = gnt1;
          addr_d  = gnt1 ? addr1 : addr0;
          wdata_d = gnt1 ? wdata1 : wdata0;
          ncs_d   = 1'b0;
          if (sel_rd) begin
            state_d = ST_RD_WAIT;
            noe_d   = 1'b0;
            cnt_d   = CNT_W'(RD_WAIT - 1);
          end else begin
            state_d = ST_WR_SETUP;
            drv_d   = 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = sram_data;
          state_d = ST_DONE;
          ncs_d   = 1'b1;
          noe_d   = 1'b1;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        wr_d    = 1'b0;
        cnt_d   = CNT_W'(WR_PULSE - 1);
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          // rnw rising into HOLD is the SRAM's write commit edge
          state_d = ST_WR_HOLD;
          wr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        state_d = ST_DONE;
        ncs_d   = 1'b1;
        drv_d   = 1'b0;
        ack0_d  = ~port_q;
        ack1_d  = port_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ncs_q   <= 1'b1;
      noe_q   <= 1'b1;
      wr_q    <= 1'b1;
      drv_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ncs_q   <= ncs_d;
      noe_q   <= noe_d;
      wr_q    <= wr_d;
      drv_q   <= drv_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign sram_data = drv_q ? wdata_q : 'z;
  assign sram_addr = addr_q;
  assign sram_ncs  = ncs_q;
  assign sram_noe  = noe_q;
  assign sram_rnw  = wr_q;
  assign rdata     = rdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench: default build (dut 0) and RD_WAIT=4/WR_PULSE=1 build (dut 1),
// each attached to a small behavioural SRAM model.
module tb_sram_arb_ctrl;

  localparam int A_RW = 2;
  localparam int A_WP = 2;
  localparam int B_RW = 4;
  localparam int B_WP = 1;

  typedef struct {
    int         port;
    logic       rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  logic        req    [2][2];
  logic        rnw_i  [2][2];
  logic [10:0] addr_i [2][2];
  logic [7:0]  wdata_i[2][2];
  logic        ack    [2][2];
  logic [7:0]  rdata  [2];
  logic [10:0] saddr  [2];
  logic        noe    [2];
  logic        srnw   [2];
  logic        ncs    [2];
  logic        busy   [2];
  wire  [7:0]  data_a;
  wire  [7:0]  data_b;

  logic [7:0]  mem_a [2048];
  logic [7:0]  mem_b [2048];
  int          rises [2];
  logic        cm_ncs[2];
  logic [7:0]  cm_data[2];
  int          lowrun[2];
  int          lastlow[2];

  exp_t qa[$];
  exp_t qb[$];

  sram_arb_ctrl #(.ADDR_W(11), .DATA_W(8), .RD_WAIT(A_RW), .WR_PULSE(A_WP)) u_dut_a (
    .clk(clk), .reset(reset),
    .req0(req[0][0]), .rnw0(rnw_i[0][0]), .addr0(addr_i[0][0]),
    .wdata0(wdata_i[0][0]), .ack0(ack[0][0]),
    .req1(req[0][1]), .rnw1(rnw_i[0][1]), .addr1(addr_i[0][1]),
    .wdata1(wdata_i[0][1]), .ack1(ack[0][1]),
    .rdata(rdata[0]), .sram_addr(saddr[0]), .sram_data(data_a),
    .sram_noe(noe[0]), .sram_rnw(srnw[0]), .sram_ncs(ncs[0]), .busy(busy[0])
  );

  sram_arb_ctrl #(.ADDR_W(11), .DATA_W(8), .RD_WAIT(B_RW), .WR_PULSE(B_WP)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0(req[1][0]), .rnw0(rnw_i[1][0]), .addr0(addr_i[1][0]),
    .wdata0(wdata_i[1][0]), .ack0(ack[1][0]),
    .req1(req[1][1]), .rnw1(rnw_i[1][1]), .addr1(addr_i[1][1]),
    .wdata1(wdata_i[1][1]), .ack1(ack[1][1]),
    .rdata(rdata[1]), .sram_addr(saddr[1]), .sram_data(data_b),
    .sram_noe(noe[1]), .sram_rnw(srnw[1]), .sram_ncs(ncs[1]), .busy(busy[1])
  );

  // SRAM models: drive on read strobe, commit on rnw rising with chip selected
  assign data_a = (!ncs[0] && !noe[0]) ? mem_a[saddr[0]] : 'z;
  assign data_b = (!ncs[1] && !noe[1]) ? mem_b[saddr[1]] : 'z;

  always @(posedge srnw[0]) begin
    rises[0]++;
    cm_ncs[0]  = ncs[0];
    cm_data[0] = data_a;
    if (!ncs[0]) mem_a[saddr[0]] = data_a;
  end

  always @(posedge srnw[1]) begin
    rises[1]++;
    cm_ncs[1]  = ncs[1];
    cm_data[1] = data_b;
    if (!ncs[1]) mem_b[saddr[1]] = data_b;
  end

  function automatic int lat(input int d, input logic rd);
    if (d == 0) return rd ? A_RW + 1 : A_WP + 3;
    return rd ? B_RW + 1 : B_WP + 3;
  endfunction

  function automatic void push(input int d, input exp_t e);
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t pop(input int d);
    return (d == 0) ? qa.pop_front() : qb.pop_front();
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    int   gp;
    if (reset) begin
      lowrun[0] = 0;
      lowrun[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (!noe[d] && !srnw[d]) begin
          failures++;
          $display("FAIL strobe_overlap dut%0d: noe=0 rnw=0, required not both low", d);
        end
        if (!srnw[d]) lowrun[d]++;
        else if (lowrun[d] != 0) begin
          lastlow[d] = lowrun[d];
          lowrun[d]  = 0;
        end
        if (ack[d][0] || ack[d][1]) begin
          checks++;
          if (ack[d][0] && ack[d][1]) begin
            failures++;
            $display("FAIL ack_overlap dut%0d: ack0=1 ack1=1, required one", d);
          end else if (qsize(d) == 0) begin
            failures++;
            $display("FAIL unexpected_ack dut%0d: ack0=%0b ack1=%0b, required none",
                     d, ack[d][0], ack[d][1]);
          end else begin
            e  = pop(d);
            gp = ack[d][1] ? 1 : 0;
            checks++;
            if (gp != e.port) begin
              failures++;
              $display("FAIL ack_port dut%0d: got %0d, required %0d", d, gp, e.port);
            end
            checks++;
            if (cyc != e.cyc) begin
              failures++;
              $display("FAIL ack_latency dut%0d: ack at cycle %0d, required %0d",
                       d, cyc, e.cyc);
            end
            if (e.rd) begin
              checks++;
              if (rdata[d] !== e.data) begin
                failures++;
                $display("FAIL rdata dut%0d: got %02h, required %02h", d, rdata[d], e.data);
              end
            end
          end
        end
      end
    end
  end

  // Caller sits on a negedge; request is raised once the controller is idle
  task automatic run_req(input int d, input int p, input logic rd,
                         input logic [10:0] a, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input bit do_push);
    int n;
    n = 0;
    while (busy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (do_push) push(d, '{port: p, rd: rd, data: exp_rd, cyc: cyc + lat(d, rd)});
    rnw_i[d][p]   = rd;
    addr_i[d][p]  = a;
    wdata_i[d][p] = wd;
    req[d][p]     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[d][p] && n < 50);
    checks++;
    if (!ack[d][p]) begin
      failures++;
      $display("FAIL ack_timeout dut%0d port%0d: no ack in %0d cycles, required ack", d, p, n);
    end
    req[d][p] = 1'b0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int c;
    int r0;
    int n;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rises[d] = 0;
      lowrun[d] = 0;
      lastlow[d] = 0;
      cm_ncs[d] = 1'b1;
      cm_data[d] = '0;
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0;
        rnw_i[d][p] = 1'b1;
        addr_i[d][p] = '0;
        wdata_i[d][p] = '0;
      end
    end
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[11'h000] = 8'h11;
    mem_a[11'h7FF] = 8'h22;
    mem_a[11'h200] = 8'h77;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_strobes", {ncs[d], noe[d], srnw[d]}, 3'b111);
      chk("reset_busy_ack", {busy[d], ack[d][0], ack[d][1]}, 3'b000);
      chk("reset_rdata", rdata[d], 0);
      chk("reset_addr", saddr[d], 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_a", {ncs[0], noe[0], srnw[0], busy[0], ack[0][0], ack[0][1]}, 6'b111000);
    end

    // port 0 write then read back
    r0 = rises[0];
    run_req(0, 0, 1'b0, 11'h123, 8'hA5, 8'h00, 1'b1);
    chk("wr_rise_count", rises[0] - r0, 1);
    chk("wr_commit_ncs", cm_ncs[0], 0);
    chk("wr_commit_data", cm_data[0], 8'hA5);
    chk("wr_low_cycles_a", lastlow[0], A_WP);
    run_req(0, 0, 1'b1, 11'h123, 8'h00, 8'hA5, 1'b1);

    // contention: port 0 first, pointer then favours port 1
    @(negedge clk);
    c = cyc;
    push(0, '{port: 0, rd: 1'b1, data: 8'h11, cyc: c + 3});
    push(0, '{port: 1, rd: 1'b1, data: 8'h22, cyc: c + 7});
    fork
      run_req(0, 0, 1'b1, 11'h000, 8'h00, 8'h00, 1'b0);
      run_req(0, 1, 1'b1, 11'h7FF, 8'h00, 8'h00, 1'b0);
    join
    @(negedge clk);
    c = cyc;
    push(0, '{port: 1, rd: 1'b1, data: 8'h11, cyc: c + 3});
    push(0, '{port: 0, rd: 1'b1, data: 8'hA5, cyc: c + 7});
    fork
      run_req(0, 0, 1'b1, 11'h123, 8'h00, 8'h00, 1'b0);
      run_req(0, 1, 1'b1, 11'h000, 8'h00, 8'h00, 1'b0);
    join

    // port 1 writes top address, port 0 reads it back
    run_req(0, 1, 1'b0, 11'h7FF, 8'h3C, 8'h00, 1'b1);
    run_req(0, 0, 1'b1, 11'h7FF, 8'h00, 8'h3C, 1'b1);

    // abort a write mid-pulse
    @(negedge clk);
    rnw_i[0][0] = 1'b0;
    addr_i[0][0] = 11'h100;
    wdata_i[0][0] = 8'hEE;
    req[0][0] = 1'b1;
    n = 0;
    while (srnw[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wr_pulse", srnw[0], 0);
    #2 reset = 1'b1;
    #1;
    chk("abort_strobes", {ncs[0], noe[0], srnw[0]}, 3'b111);
    chk("abort_busy_ack", {busy[0], ack[0][0], ack[0][1]}, 3'b000);
    chk("abort_rdata", rdata[0], 0);
    req[0][0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_req(0, 0, 1'b1, 11'h200, 8'h00, 8'h77, 1'b1);
    repeat (10) @(negedge clk);

    // slow-read / short-pulse build
    run_req(1, 0, 1'b0, 11'h010, 8'h5A, 8'h00, 1'b1);
    chk("wr_low_cycles_b", lastlow[1], B_WP);
    run_req(1, 0, 1'b1, 11'h010, 8'h00, 8'h5A, 1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
